audio_sample_serializer: RTL and testbench
==========================================

// Module: audio_sample_serializer
// PURPOSE
//  Sink end of the 32-bit parallel audio sample interface. Accepts stereo
//  words x[31:16]=left, x[15:0]=right via valid/ready into a 2-entry FIFO.
//  Shifts them out as a standard I2S serial stream: bclk, lrclk, sdata.
//  Sits between the sample source and the DAC pin model in the audio test bench.
// PARAMETERS
//  BCLK_DIV  2  c cycles per bclk half-period; legal range >=1
//  CNT_W     16 width of underrun counter
// PORTS
//  c             in   1      clock, all logic on posedge c
//  r_n           in   1      reset, asynchronous, active-low
//  en            in   1      run enable
//  x             in   32     sample word {left[15:0], right[15:0]}
//  x_valid       in   1      x holds a sample
//  x_ready       out  1      FIFO can accept; high when FIFO not full
//  bclk          out  1      serial bit clock
//  lrclk         out  1      word select: 0=left, 1=right
//  sdata         out  1      serial data, MSB first
//  busy          out  1      1 in RUN state
//  underrun      out  1      one-c-cycle pulse, frame loaded with zeros
//  underrun_cnt  out  CNT_W  saturating count of underrun pulses
// BEHAVIOUR
//  Reset (async, r_n=0): bclk=0, lrclk=1, sdata=0, busy=0, underrun=0,
//   underrun_cnt=0, FIFO emptied, x_ready=1 after release, state IDLE.
//  Reset mid-frame aborts immediately; no partial frame completes.
//  FIFO: push when x_valid&&x_ready; x_ready=!full from registered state.
//   Full FIFO: x_ready=0; a pop in that cycle does not enable a same-cycle push.
//   Accepts pushes in IDLE as well as RUN.
//  Divider: in RUN, bclk toggles every BCLK_DIV c cycles; bclk is 0 on IDLE->RUN.
//   A falling edge is the c cycle where bclk is updated 1->0; all
//   lrclk/sdata/shift updates happen only in that cycle.
//  Frame counter bit_cnt (5 bits) increments on each falling edge and wraps 31->0.
//  Falling edge with bit_cnt==31, the load edge (E0):
//   - lrclk<=0; sdata<=sreg[31] (previous frame's right LSB).
//   - if FIFO not empty, sreg<=FIFO head and pop.
//   - if FIFO empty, sreg<=0, underrun<=1 for 1 c cycle, underrun_cnt++,
//     saturating at all-ones.
//   - a push arriving in the same cycle as an empty-FIFO load edge is kept
//     for the next frame; the current frame still underruns.
//  Other falling edges: sdata<=sreg[31], sreg<=sreg<<1.
//   bit_cnt==15 also sets lrclk<=1.
//  Resulting I2S timing: left MSB on sdata at E1, one bclk after lrclk falls.
//   Left LSB at E16, right MSB at E17, right LSB at E32 (next E0).
//   One frame = 32 bclk periods = 64*BCLK_DIV c cycles.
//  FSM IDLE: bclk=0, lrclk=1, sdata=0, busy=0, no underruns counted.
//   en=1 -> RUN with bit_cnt=31, divider cleared.
//   First rising edge after BCLK_DIV cycles; first falling edge is E0 of frame 1.
//  FSM RUN: busy=1; en sampled only at load edges.
//   en=0 there -> IDLE; that edge does no load, no pop, no underrun.
//   sdata still outputs the final right LSB for one c cycle, then outputs return
//   to IDLE values.
// TESTING
//  1 Reset: r_n=0 mid-frame, BCLK_DIV=2 -> all outputs at reset values
//    within the same cycle, FIFO flushed, x_ready=1 after release.
//  2 Single frame: push 32'hA5A5_0F0F, en=1.
//    -> E0 at c cycle 4; lrclk low 16 bclk periods.
//    -> sdata bits A5A5 MSB-first from E1, 0F0F from E17; no underrun.
//  3 Backpressure: hold x_valid=1, en=0, push 3 words -> x_ready=0 after
//    2 accepts; third word accepted only after first pop.
//  4 Underrun: en=1 with empty FIFO -> underrun pulses once per frame,
//    sdata=0, underrun_cnt increments 1,2,3.
//    Preload underrun_cnt via force to 16'hFFFF -> stays 16'hFFFF.
//  5 Stop: en=0 mid-frame -> current frame completes, final right LSB shown.
//    -> IDLE (bclk=0, lrclk=1, busy=0); queued FIFO word retained.
//  6 Streaming: 100 random words back-to-back, BCLK_DIV=1 and 3.
//    -> deserialising bench model recovers every word in order, zero underruns.

Source files
------------

// File: rtl/audio_sample_serializer.sv
// Parallel stereo sample sink: 2-entry FIFO feeding an I2S serializer (bclk/lrclk/sdata).
// Outputs are registered; frames load from the FIFO head at the bit_cnt==31 falling edge.
`timescale 1ns/1ps
module audio_sample_serializer #(
  parameter int BCLK_DIV = 2,
  parameter int CNT_W    = 16
) (
  input  logic             c,
  input  logic             r_n,
  input  logic             en,
  input  logic [31:0]      x,
  input  logic             x_valid,
  output logic             x_ready,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             busy,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [31:0]      sreg;

  logic [31:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;
  logic        fall_edge;
  logic        load_edge;

  assign x_ready   = (count != 2'd2);
  assign push      = x_valid && x_ready;
  assign fall_edge = (state == RUN) && (div_cnt == DIV_LAST) && bclk;
  assign load_edge = fall_edge && (bit_cnt == 5'd31);
  // A stop request at the load edge suppresses the pop as well as the underrun.
  assign pop       = load_edge && en && (count != 2'd0);

  always_ff @(posedge c or negedge r_n) begin
    if (!r_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= x;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge c or negedge r_n) begin
    if (!r_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= 5'd31;
      sreg         <= '0;
      bclk         <= 1'b0;
      lrclk        <= 1'b1;
      sdata        <= 1'b0;
      busy         <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= 1'b0;
      if (state == IDLE) begin
        bclk    <= 1'b0;
        lrclk   <= 1'b1;
        sdata   <= 1'b0;
        sreg    <= '0;
        div_cnt <= '0;
        bit_cnt <= 5'd31;
        busy    <= en;
        if (en) begin
          state <= RUN;
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        bclk    <= ~bclk;
        if (fall_edge) begin
          sdata <= sreg[31];
          if (load_edge) begin
            if (!en) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              bit_cnt <= 5'd0;
              lrclk   <= 1'b0;
              if (pop) begin
                sreg <= mem[rd_ptr];
              end else begin
                sreg     <= '0;
                underrun <= 1'b1;
                if (underrun_cnt != {CNT_W{1'b1}}) begin
                  underrun_cnt <= underrun_cnt + 1'b1;
                end
              end
            end
          end else begin
            sreg    <= {sreg[30:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              lrclk <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_serializer.sv
// Directed bench for audio_sample_serializer: reset, single frame, backpressure,
// underrun/saturation, stop, and streaming through an I2S deserialising model.
`timescale 1ns/1ps
module tb_audio_sample_serializer;

  logic c = 1'b0;
  always #5 c = ~c;

  logic        r_n, en, x_valid;
  logic [31:0] x;
  logic        x_ready, bclk, lrclk, sdata, busy, underrun;
  logic [15:0] underrun_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  audio_sample_serializer #(.BCLK_DIV(2), .CNT_W(16)) dut (
    .c(c), .r_n(r_n), .en(en), .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .busy(busy),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  // Streaming instances: index 0 runs BCLK_DIV=1, index 1 runs BCLK_DIV=3.
  logic        en_s [2];
  logic [31:0] x_s [2];
  logic        xv_s [2];
  logic        rdy_s [2], bclk_s [2], lr_s [2], sd_s [2], busy_s [2], ur_s [2];
  logic [15:0] cnt_s [2];

  audio_sample_serializer #(.BCLK_DIV(1), .CNT_W(16)) s1 (
    .c(c), .r_n(r_n), .en(en_s[0]), .x(x_s[0]), .x_valid(xv_s[0]), .x_ready(rdy_s[0]),
    .bclk(bclk_s[0]), .lrclk(lr_s[0]), .sdata(sd_s[0]), .busy(busy_s[0]),
    .underrun(ur_s[0]), .underrun_cnt(cnt_s[0])
  );

  audio_sample_serializer #(.BCLK_DIV(3), .CNT_W(16)) s3 (
    .c(c), .r_n(r_n), .en(en_s[1]), .x(x_s[1]), .x_valid(xv_s[1]), .x_ready(rdy_s[1]),
    .bclk(bclk_s[1]), .lrclk(lr_s[1]), .sdata(sd_s[1]), .busy(busy_s[1]),
    .underrun(ur_s[1]), .underrun_cnt(cnt_s[1])
  );

  logic [31:0] exp_w [100];
  logic        prev_b [2];
  logic        synced [2];
  int          nb [2];
  logic [31:0] sr_m [2];
  int          rx_cnt [2];

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge c);
  endtask

  // Walks E1..E32 of a BCLK_DIV=2 frame on the main instance.
  task automatic frame_check(input logic [31:0] w, input int first, input logic stopping,
                             input string tag);
    logic [31:0] s;
    logic        e_lr;
    s = w;
    for (int k = 1; k <= 32; k++) begin
      tick((k == 1) ? first : 4);
      e_lr = (k >= 16 && k < 32) ? 1'b1 : ((k == 32) ? stopping : 1'b0);
      chk1($sformatf("%s_sdata_E%0d", tag, k), sdata, s[31]);
      chk1($sformatf("%s_lrclk_E%0d", tag, k), lrclk, e_lr);
      chk1($sformatf("%s_bclk_E%0d", tag, k), bclk, 1'b0);
      s = s << 1;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      prev_b[k] = 1'b0;
      synced[k] = 1'b0;
      nb[k]     = 0;
      sr_m[k]   = '0;
      rx_cnt[k] = 0;
    end
  end

  // I2S receiver: bit k of a frame appears at the k-th falling edge after lrclk falls.
  always @(negedge c) begin
    for (int k = 0; k < 2; k++) begin
      if (prev_b[k] && !bclk_s[k]) begin
        if (synced[k]) begin
          sr_m[k] = {sr_m[k][30:0], sd_s[k]};
          nb[k]++;
          if (nb[k] == 32) begin
            nb[k] = 0;
            if (rx_cnt[k] < 100)
              chk32($sformatf("stream%0d_word%0d", k, rx_cnt[k]), sr_m[k], exp_w[rx_cnt[k]]);
            else
              chk32($sformatf("stream%0d_extra_word", k), 32'(rx_cnt[k]), 32'd99);
            rx_cnt[k]++;
          end
        end else if (!lr_s[k] && busy_s[k]) begin
          synced[k] = 1'b1;
          nb[k]     = 0;
        end
      end
      if (!busy_s[k]) synced[k] = 1'b0;
      prev_b[k] = bclk_s[k];
    end
  end

  task automatic stream(input int k);
    int g;
    for (int i = 0; i < 100; i++) exp_w[i] = $urandom;
    rx_cnt[k] = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          int gf;
          gf = 0;
          x_s[k]  = exp_w[i];
          xv_s[k] = 1'b1;
          while (!rdy_s[k] && gf < 2000) begin
            tick(1);
            gf++;
          end
          chk1($sformatf("stream%0d_ready_w%0d", k, i), rdy_s[k], 1'b1);
          tick(1);
        end
        xv_s[k] = 1'b0;
      end
      begin
        int ge;
        ge = 0;
        en_s[k] = 1'b1;
        while (rx_cnt[k] < 99 && ge < 50000) begin
          tick(1);
          ge++;
        end
        chk32($sformatf("stream%0d_reached_99", k), 32'(rx_cnt[k]), 32'd99);
        en_s[k] = 1'b0;
      end
    join
    g = 0;
    while (busy_s[k] && g < 1000) begin
      tick(1);
      g++;
    end
    chk1($sformatf("stream%0d_idle", k), busy_s[k], 1'b0);
    tick(2);
    chk32($sformatf("stream%0d_count", k), 32'(rx_cnt[k]), 32'd100);
    chk16($sformatf("stream%0d_underruns", k), cnt_s[k], 16'h0000);
  endtask

  initial begin
    r_n = 1'b0; en = 1'b0; x_valid = 1'b0; x = '0;
    for (int k = 0; k < 2; k++) begin
      en_s[k] = 1'b0; xv_s[k] = 1'b0; x_s[k] = '0;
    end

    // Reset values
    tick(2);
    chk1("rst_bclk", bclk, 1'b0);
    chk1("rst_lrclk", lrclk, 1'b1);
    chk1("rst_sdata", sdata, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_underrun", underrun, 1'b0);
    chk16("rst_cnt", underrun_cnt, 16'h0000);
    r_n = 1'b1;
    tick(1);
    chk1("rel_ready", x_ready, 1'b1);

    // Single frame
    x = 32'hA5A5_0F0F; x_valid = 1'b1;
    tick(1);
    x_valid = 1'b0;
    chk1("push1_ready", x_ready, 1'b1);
    en = 1'b1;
    tick(1);
    chk1("run_busy", busy, 1'b1);
    chk1("run_bclk0", bclk, 1'b0);
    chk1("run_lrclk1", lrclk, 1'b1);
    tick(2);
    chk1("first_rise", bclk, 1'b1);
    tick(2);
    chk1("e0_bclk", bclk, 1'b0);
    chk1("e0_lrclk", lrclk, 1'b0);
    chk1("e0_sdata", sdata, 1'b0);
    chk1("e0_underrun", underrun, 1'b0);
    frame_check(32'hA5A5_0F0F, 4, 1'b0, "f1");

    // Underruns on an empty FIFO
    chk1("ur1_pulse", underrun, 1'b1);
    chk16("ur1_cnt", underrun_cnt, 16'h0001);
    tick(1);
    chk1("ur1_pulse_end", underrun, 1'b0);
    tick(127);
    chk1("ur2_pulse", underrun, 1'b1);
    chk16("ur2_cnt", underrun_cnt, 16'h0002);
    tick(64);
    chk1("ur_zero_sdata", sdata, 1'b0);
    chk1("ur_lrclk_right", lrclk, 1'b1);
    tick(64);
    chk16("ur3_cnt", underrun_cnt, 16'h0003);
    force dut.underrun_cnt = 16'hFFFF;
    tick(1);
    release dut.underrun_cnt;
    tick(127);
    chk1("sat_pulse", underrun, 1'b1);
    chk16("sat_cnt", underrun_cnt, 16'hFFFF);

    // Reset mid-frame with a full FIFO
    tick(40);
    x = 32'h1111_2222; x_valid = 1'b1;
    tick(1);
    x = 32'h3333_4444;
    tick(1);
    x_valid = 1'b0;
    chk1("full_ready", x_ready, 1'b0);
    tick(12);
    chk1("pre_rst_bclk", bclk, 1'b1);
    r_n = 1'b0; en = 1'b0;
    #1;
    chk1("mid_rst_bclk", bclk, 1'b0);
    chk1("mid_rst_lrclk", lrclk, 1'b1);
    chk1("mid_rst_sdata", sdata, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk16("mid_rst_cnt", underrun_cnt, 16'h0000);
    tick(2);
    r_n = 1'b1;
    tick(1);
    chk1("mid_rel_ready", x_ready, 1'b1);
    en = 1'b1;
    tick(5);
    chk1("flush_underrun", underrun, 1'b1);
    chk16("flush_cnt", underrun_cnt, 16'h0001);

    // Stop after a data frame; queued word kept
    x = 32'h8001_C003; x_valid = 1'b1;
    tick(1);
    x_valid = 1'b0;
    tick(127);
    chk1("w1_no_underrun", underrun, 1'b0);
    chk1("w1_lrclk", lrclk, 1'b0);
    en = 1'b0;
    x = 32'h1234_5678; x_valid = 1'b1;
    tick(1);
    x_valid = 1'b0;
    tick(63);
    chk1("w1_left_lsb", sdata, 1'b1);
    chk1("w1_lrclk_r", lrclk, 1'b1);
    tick(64);
    chk1("stop_right_lsb", sdata, 1'b1);
    chk1("stop_lrclk", lrclk, 1'b1);
    chk1("stop_bclk", bclk, 1'b0);
    chk1("stop_busy", busy, 1'b0);
    chk1("stop_underrun", underrun, 1'b0);
    tick(1);
    chk1("idle_sdata", sdata, 1'b0);
    chk1("idle_lrclk", lrclk, 1'b1);
    tick(8);
    chk1("idle_bclk", bclk, 1'b0);
    chk1("idle_busy", busy, 1'b0);

    // Backpressure
    x = 32'h0BAD_F00D; x_valid = 1'b1;
    tick(1);
    chk1("bp_full", x_ready, 1'b0);
    x = 32'hC0DE_CAFE;
    tick(3);
    chk1("bp_hold", x_ready, 1'b0);
    en = 1'b1;
    tick(4);
    chk1("bp_before_pop", x_ready, 1'b0);
    tick(1);
    chk1("bp_pop_no_push", x_ready, 1'b1);
    chk1("bp_e0_underrun", underrun, 1'b0);
    tick(1);
    chk1("bp_third_accepted", x_ready, 1'b0);
    x_valid = 1'b0;
    frame_check(32'h1234_5678, 3, 1'b0, "w2");
    frame_check(32'h0BAD_F00D, 4, 1'b0, "w3");
    en = 1'b0;
    frame_check(32'hC0DE_CAFE, 4, 1'b1, "w4");
    tick(1);
    chk1("end_busy", busy, 1'b0);
    chk1("end_sdata", sdata, 1'b0);
    chk16("end_cnt", underrun_cnt, 16'h0001);
    chk1("end_ready", x_ready, 1'b1);

    // Streaming
    stream(0);
    stream(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
